// File: rtl/vga_pkg.sv
// Shared types and constants for the display timing generator and its pattern source.
package vga_pkg;

  typedef enum logic [1:0] {
    PAT_SOLID = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_RAMP  = 2'd3
  } pattern_e;

  // Bar colours, left to right, as {r,g,b}.
  localparam logic [23:0] BAR_RGB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/tpg_pixel.sv
// Combinational test-pattern colour for one pixel; the caller masks blanking and registers it.
module tpg_pixel
  import vga_pkg::*;
#(
  parameter int          CORDW     = 11,
  parameter int          H_RES     = 640,
  parameter logic [23:0] SOLID_RGB = 24'hFFFFFF,
  parameter int          CHK_LOG2  = 5
) (
  input  logic signed [CORDW-1:0] i_sx,
  input  logic                    i_chk_y,
  input  pattern_e                i_mode,
  output logic [23:0]             o_rgb
);

  localparam int BAR_W = H_RES / 8;

  logic [CORDW-1:0] w_ux;
  logic [CORDW-1:0] w_bar;

  // Only meaningful for visible pixels, where sx is non-negative.
  assign w_ux  = i_sx;
  assign w_bar = w_ux / CORDW'(BAR_W);

  always_comb begin
    o_rgb = 24'h000000;
    case (i_mode)
      PAT_SOLID: o_rgb = SOLID_RGB;
      PAT_BARS:  if (w_bar < CORDW'(8)) o_rgb = BAR_RGB[w_bar[2:0]];
      PAT_CHECK: o_rgb = (i_sx[CHK_LOG2] ^ i_chk_y) ? 24'h000000 : 24'hFFFFFF;
      PAT_RAMP:  o_rgb = {3{i_sx[7:0]}};
      default:   o_rgb = 24'h000000;
    endcase
  end

endmodule

// File: rtl/vga_timing_tpg.sv
// Display timing generator: signed raster counters, sync/de decode, strobes and a
// registered test-pattern output stage, all advancing only on pixel-enable.
module vga_timing_tpg
  import vga_pkg::*;
#(
  parameter int          CORDW     = 11,
  parameter int          H_RES     = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_RES     = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33,
  parameter logic        H_POL     = 1'b0,
  parameter logic        V_POL     = 1'b0,
  parameter logic [23:0] SOLID_RGB = 24'hFFFFFF,
  parameter int          CHK_LOG2  = 5
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix,
  input  logic                    en,
  input  logic [1:0]              pattern_mode,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    de,
  output logic                    frame,
  output logic                    line,
  output logic signed [CORDW-1:0] sx,
  output logic signed [CORDW-1:0] sy,
  output logic [7:0]              r,
  output logic [7:0]              g,
  output logic [7:0]              b
);

  localparam int H_STA_I = -(H_FP + H_SYNC + H_BP);
  localparam int V_STA_I = -(V_FP + V_SYNC + V_BP);
  localparam int C_MAX   = 2**(CORDW-1) - 1;

  localparam logic signed [CORDW-1:0] H_STA  = CORDW'(H_STA_I);
  localparam logic signed [CORDW-1:0] HS_STA = CORDW'(H_STA_I + H_FP);
  localparam logic signed [CORDW-1:0] HS_END = CORDW'(H_STA_I + H_FP + H_SYNC - 1);
  localparam logic signed [CORDW-1:0] H_END  = CORDW'(H_RES - 1);
  localparam logic signed [CORDW-1:0] V_STA  = CORDW'(V_STA_I);
  localparam logic signed [CORDW-1:0] VS_STA = CORDW'(V_STA_I + V_FP);
  localparam logic signed [CORDW-1:0] VS_END = CORDW'(V_STA_I + V_FP + V_SYNC - 1);
  localparam logic signed [CORDW-1:0] V_END  = CORDW'(V_RES - 1);

  if (H_RES < 8) begin : g_hres_chk
    $error("H_RES must be at least 8");
  end
  if (CORDW < 8 || CHK_LOG2 >= CORDW || H_RES - 1 > C_MAX || V_RES - 1 > C_MAX ||
      H_STA_I < -(C_MAX + 1) || V_STA_I < -(C_MAX + 1)) begin : g_cordw_chk
    $error("CORDW too narrow for the configured timing");
  end

  logic signed [CORDW-1:0] r_x;
  logic signed [CORDW-1:0] r_y;
  pattern_e                r_mode;

  logic        w_line_end;
  logic        w_start;
  logic        w_de;
  logic        w_hs_act;
  logic        w_vs_act;
  logic [23:0] w_rgb;

  assign w_line_end = (r_x == H_END);
  assign w_start    = (r_x == H_STA) && (r_y == V_STA);
  assign w_de       = !r_x[CORDW-1] && !r_y[CORDW-1];
  assign w_hs_act   = (r_x >= HS_STA) && (r_x <= HS_END);
  assign w_vs_act   = (r_y >= VS_STA) && (r_y <= VS_END);

  tpg_pixel #(
    .CORDW     (CORDW),
    .H_RES     (H_RES),
    .SOLID_RGB (SOLID_RGB),
    .CHK_LOG2  (CHK_LOG2)
  ) u_tpg (
    .i_sx    (r_x),
    .i_chk_y (r_y[CHK_LOG2]),
    .i_mode  (r_mode),
    .o_rgb   (w_rgb)
  );

  // Outputs reflect the counter value held before each enabled edge (one-cycle latency).
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_x    <= H_STA;
      r_y    <= V_STA;
      r_mode <= PAT_SOLID;
      hsync  <= !H_POL;
      vsync  <= !V_POL;
      de     <= 1'b0;
      frame  <= 1'b0;
      line   <= 1'b0;
      sx     <= H_STA;
      sy     <= V_STA;
      r      <= 8'h00;
      g      <= 8'h00;
      b      <= 8'h00;
    end else if (en) begin
      if (w_start) r_mode <= pattern_e'(pattern_mode);
      if (w_line_end) begin
        r_x <= H_STA;
        r_y <= (r_y == V_END) ? V_STA : r_y + CORDW'(1);
      end else begin
        r_x <= r_x + CORDW'(1);
      end
      hsync <= w_hs_act ? H_POL : !H_POL;
      vsync <= w_vs_act ? V_POL : !V_POL;
      de    <= w_de;
      frame <= w_start;
      line  <= (r_x == H_STA);
      sx    <= r_x;
      sy    <= r_y;
      r     <= w_de ? w_rgb[23:16] : 8'h00;
      g     <= w_de ? w_rgb[15:8]  : 8'h00;
      b     <= w_de ? w_rgb[7:0]   : 8'h00;
    end
  end

endmodule
